bram_sdp: RTL and testbench

- Simple dual-port block RAM: port A write-only, port B read-only, both on one clock.
- Default geometry is 307200 x 16 bits, one 640x480 RGB565 frame, with a 19-bit address.
- Used as the frame/scratch buffer between a pixel producer (port A) and a display/reader (port B).
- Must infer FPGA block RAM: no reset on the storage array.

---
 rtl/bram_sdp_pkg.sv | 8 +
 rtl/bram_out_pipe.sv | 12 +
 rtl/bram_sdp.sv | 40 ++++
 tb/tb_bram_sdp.sv | 90 +++++++++
 4 files changed

// File: rtl/bram_sdp_pkg.sv
// bram_sdp_pkg: frame-buffer geometry shared by the block RAM and its users
package bram_sdp_pkg;
  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W = 19;
  localparam int PIX_W     = 16;
endpackage

// File: rtl/bram_out_pipe.sv
// bram_out_pipe: single output register stage with synchronous clear
module bram_out_pipe #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? '0 : d;
endmodule

// File: rtl/bram_sdp.sv
// bram_sdp: simple dual-port block RAM, write port A, read-first read port B
module bram_sdp
  import bram_sdp_pkg::*;
#(
  parameter int DATA_W       = PIX_W,
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DEPTH        = FB_DEPTH,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd;
  logic              a_ok;
  logic              b_ok;
  assign a_ok = {1'b0, addra} < LIM;
  assign b_ok = {1'b0, addrb} < LIM;
  always_ff @(posedge clk)
    if (wea && a_ok) mem[addra] <= dina;
  // Reading in a separate block with nonblocking write gives read-first collisions
  always_ff @(posedge clk)
    rd <= rst ? '0 : (b_ok ? mem[addrb] : '0);
  if (READ_LATENCY == 2) begin : g_pipe
    bram_out_pipe #(.W(DATA_W)) u_pipe (
      .clk(clk),
      .rst(rst),
      .d  (rd),
      .q  (doutb)
    );
  end else begin : g_direct
    assign doutb = rd;
  end
endmodule

// File: tb/tb_bram_sdp.sv
// tb_bram_sdp: randomized bench against a sparse read-first memory model
module tb_bram_sdp;
  import bram_sdp_pkg::*;
  localparam int LAT = 1;
  logic        clk = 0;
  logic        rst = 1;
  logic [18:0] addra = '0;
  logic [15:0] dina = '0;
  logic        wea = 0;
  logic [18:0] addrb = '0;
  logic [15:0] doutb;
  int checks = 0;
  int errors = 0;
  logic [15:0] ref_mem [int];
  logic [15:0] outq [$];

  bram_sdp #(.READ_LATENCY(LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .addra(addra),
    .dina (dina),
    .wea  (wea),
    .addrb(addrb),
    .doutb(doutb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] peek(input int a);
    return (a < FB_DEPTH && ref_mem.exists(a)) ? ref_mem[a] : 16'h0;
  endfunction

  task automatic step(input string tag, input logic r, input logic we,
                      input int aa, input logic [15:0] da, input int ab);
    logic [15:0] v;
    rst = r; wea = we; addra = 19'(aa); dina = da; addrb = 19'(ab);
    @(posedge clk);
    v = peek(ab);
    if (we && aa < FB_DEPTH) ref_mem[aa] = da;
    if (r) begin
      outq.delete();
      repeat (LAT) outq.push_back(16'h0);
    end else begin
      outq.push_back(v);
      void'(outq.pop_front());
    end
    #1 check(tag, doutb, outq[0]);
  endtask

  initial begin
    repeat (LAT) outq.push_back(16'h0);
    repeat (3) step("reset", 1, 0, 0, 0, 0);
    repeat (LAT) step("reset_release", 0, 0, 0, 0, 0);
    step("basic_wr5", 0, 1, 5, 16'h1234, 0);
    step("basic_wr6", 0, 1, 6, 16'hBEEF, 0);
    step("basic_rd5", 0, 0, 0, 0, 5);
    step("basic_rd6", 0, 0, 0, 0, 6);
    repeat (LAT) step("basic_flush", 0, 0, 0, 0, 0);
    step("coll_init", 0, 1, 3, 16'h00AA, 0);
    step("coll_same", 0, 1, 3, 16'h5555, 3);
    step("coll_after", 0, 0, 0, 0, 3);
    repeat (LAT) step("coll_flush", 0, 0, 0, 0, 0);
    step("oor_wr", 0, 1, FB_DEPTH, 16'hFFFF, 0);
    step("oor_rd", 0, 0, 0, 0, FB_DEPTH);
    step("oor_rd0", 0, 0, 0, 0, 0);
    step("oor_rdmax", 0, 0, 0, 0, 524287);
    repeat (LAT) step("oor_flush", 0, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++)
      step("stress", 0, 1, int'($urandom_range(0, 15)), 16'($urandom), i % 16);
    for (int i = 0; i < 16; i++)
      step("mid_fill", 0, 1, i, 16'(16'h0100 + i * 16'h0111), 0);
    for (int i = 0; i < 40; i++)
      step("mid_reset", (i == 17), 0, 0, 0, i % 16);
    for (int i = 0; i < 40; i++)
      step("mid_reset_wr", (i == 9), 1, int'($urandom_range(0, 15)), 16'($urandom), i % 16);
    for (int i = 0; i < 16; i++)
      step("final_readback", 0, 0, 0, 0, i);
    repeat (LAT) step("final_flush", 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
